// File: rtl/arb_mem_responder_pkg.sv
// Shared definitions for the arbiter request interface: opcodes used by all
// requesters and the responder state encoding.
package arb_mem_responder_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_READ  = 4'b0001;
  localparam logic [3:0] OP_WRITE = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic op_is_defined(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_READ) || (op == OP_WRITE) || (op == OP_CLEAR);
  endfunction

  function automatic logic op_is_write(input logic [3:0] op);
    return (op == OP_WRITE) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/arb_mem_responder_sp_ram.sv
// Single-port synchronous word RAM: write-first, registered one-cycle read.
module arb_mem_responder_sp_ram #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write commits at the edge; a read registers the addressed word into q.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      q         <= wdata;
    end else if (re) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/arb_mem_responder.sv
// Memory-side responder behind the arbiter: writes/clears commit on accept,
// reads return through a separate rts/rtr response channel.
import arb_mem_responder_pkg::*;

module arb_mem_responder #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] arb_addr,
  input  logic [DATA_W-1:0] arb_wr_data,
  input  logic [3:0]        arb_op,
  input  logic              arb_rts_in,
  output logic              arb_rtr_out,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_rts_out,
  input  logic              rd_rtr_in,
  output logic              op_err,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              req_xfc;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] ram_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs decode from state only; next-state follows transfers.
  always_comb begin
    state_nxt   = IDLE;
    arb_rtr_out = 1'b0;
    rd_rts_out  = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        arb_rtr_out = 1'b1;
        busy        = 1'b0;
        state_nxt   = (arb_rts_in && (arb_op == OP_READ)) ? RD : IDLE;
      end
      RD:   state_nxt = RESP;
      RESP: begin
        rd_rts_out = 1'b1;
        state_nxt  = rd_rtr_in ? IDLE : RESP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request transfer and RAM strobes; a write coincident with reset is dropped.
  always_comb begin
    req_xfc = arb_rts_in && arb_rtr_out;
    wr_en   = req_xfc && op_is_write(arb_op) && !rst;
    rd_en   = req_xfc && (arb_op == OP_READ);
  end

  // Capture RAM output in RD and hold it through RESP.
  always_ff @(posedge clk) begin
    if (rst)               rd_data <= '0;
    else if (state == RD)  rd_data <= ram_q;
  end

  // Sticky flag for accepted undefined opcodes.
  always_ff @(posedge clk) begin
    if (rst)                                  op_err <= 1'b0;
    else if (req_xfc && !op_is_defined(arb_op)) op_err <= 1'b1;
  end

  arb_mem_responder_sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sp_ram (
    .clk  (clk),
    .we   (wr_en),
    .re   (rd_en),
    .addr (arb_addr),
    .wdata(arb_wr_data),
    .q    (ram_q)
  );

endmodule
